fwd_hazard_unit: RTL

- Parametrised successor to the EX-stage forwarding logic. Selects bypass sources for NUM_SRC operands across NUM_STG pipeline stages plus a multi-cycle (mul/div/load-miss) writeback port.
- Keeps a per-register scoreboard for in-flight multi-cycle writes and raises a pipeline stall on load-use, scoreboard (RAW) and WAW hazards.
- Sits beside the EX stage and drives the operand muxes and the IF/ID/EX stall enables.

---
 rtl/fwd_hazard_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and hazard detection.
// Picks a bypass source per operand from the pipeline stages or the multi-cycle writeback port.
// Tracks in-flight multi-cycle writes in a per-register scoreboard, raises stall on load-use,
// scoreboard RAW and WAW hazards, and counts stalled cycles.
module fwd_hazard_unit #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned NUM_STG = 2,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned SELW   = $clog2(NUM_STG + 2)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [NUM_SRC-1:0]        ex_rs_used,
    input  logic [NUM_STG*REG_AW-1:0] stg_rd,
    input  logic [NUM_STG-1:0]        stg_we,
    input  logic [NUM_STG-1:0]        stg_ready,
    input  logic                      mc_issue,
    input  logic [REG_AW-1:0]         mc_rd,
    input  logic                      mc_wb_valid,
    input  logic [REG_AW-1:0]         mc_wb_rd,
    input  logic                      stall_cnt_clr,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      stall,
    output logic                      mc_accept,
    output logic [2**REG_AW-1:0]      busy,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int unsigned NREG = 2 ** REG_AW;

    logic [NREG-1:0]    busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] src_stall;
    logic               waw_stall;
    logic               wb_hits_mc_rd;

    // Per-source bypass selection; first matching candidate wins, youngest stage first.
    always_comb begin
        logic [REG_AW-1:0] rs;
        logic              hit;
        logic [SELW-1:0]   sel;
        logic              st;
        fwd_sel   = '0;
        src_stall = '0;
        rs        = '0;
        hit       = 1'b0;
        sel       = '0;
        st        = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs  = ex_rs[i*REG_AW +: REG_AW];
            hit = 1'b0;
            sel = '0;
            st  = 1'b0;
            if (ex_rs_used[i] && (rs != '0)) begin
                for (int k = 0; k < NUM_STG; k++) begin
                    if (!hit && stg_we[k] && (stg_rd[k*REG_AW +: REG_AW] == rs)) begin
                        hit = 1'b1;
                        sel = SELW'(k + 1);
                        // A not-ready winner stalls; older stages hold stale data for rs.
                        st  = ~stg_ready[k];
                    end
                end
                if (!hit && mc_wb_valid && (mc_wb_rd == rs)) begin
                    hit = 1'b1;
                    sel = SELW'(NUM_STG + 1);
                end
                // Pending multi-cycle write with nothing to bypass from.
                if (!hit && busy_q[rs]) begin
                    st = 1'b1;
                end
            end
            fwd_sel[i*SELW +: SELW] = sel;
            src_stall[i]            = st;
        end
    end

    // WAW: a second multi-cycle write to a still-pending register must wait for the first,
    // unless the first one retires in this very cycle.
    always_comb begin
        wb_hits_mc_rd = mc_wb_valid && (mc_wb_rd == mc_rd);
        waw_stall     = mc_issue && (mc_rd != '0) && busy_q[mc_rd] && !wb_hits_mc_rd;
        stall         = (|src_stall) || waw_stall;
        mc_accept     = mc_issue && !stall;
    end

    // Scoreboard next state: retire first, then issue so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (mc_wb_valid) begin
            busy_d[mc_wb_rd] = 1'b0;
        end
        if (mc_accept && (mc_rd != '0)) begin
            busy_d[mc_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Stall counter next state: clear dominates, increment saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_cnt_clr) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign stall_cnt = cnt_q;

endmodule
